// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and its read-side stream adapter.
package fifo_pkg;

    localparam int unsigned WIDTH = 4;

    typedef logic [WIDTH-1:0] fifo_word_t;

    // Bits needed to hold an occupancy count from 0 to depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_ring_buf.sv
// Small circular buffer with push/pop and an occupancy count.
// The head word is presented combinationally from the registers.
module stream_ring_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = fifo_pkg::WIDTH,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] occ
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             pop_fire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy; a pop on an empty buffer is ignored.
    always_comb begin
        pop_fire = pop && (occ_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_fire) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop_fire})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (occ_q != '0);
    assign occ        = occ_q;

    // The issuer must never land a word into a full buffer that is not draining.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && (occ_q == OCC_FULL) && !pop_fire));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO read port (rd_en strobe, data one cycle later) into a
// valid/ready stream. Reads are issued from registered state only, so
// out_ready never reaches fifo_rd_en combinationally.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter  int unsigned WIDTH     = fifo_pkg::WIDTH,
    parameter  int unsigned BUF_DEPTH = 3,
    localparam int unsigned CNT_W     = cnt_width(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_buf_empty,
    input  logic [WIDTH-1:0] fifo_buf_out,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);

    logic             pend_q, pend_d;
    logic [CNT_W-1:0] occ;
    logic [CNT_W:0]   outstanding;

    // Issue a read only while buffered plus in-flight words leave room for it.
    always_comb begin
        outstanding = {1'b0, occ} + {{CNT_W{1'b0}}, pend_q};
        fifo_rd_en  = !rst && !fifo_buf_empty && (outstanding < DEPTH_EXT);
        pend_d      = fifo_rd_en;
    end

    // In-flight marker: the word read this cycle lands on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    stream_ring_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .push       (pend_q),
        .push_data  (fifo_buf_out),
        .pop        (out_ready),
        .head_data  (out_data),
        .head_valid (out_valid),
        .occ        (occ)
    );

    assign out_count = occ;

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
Downstream stage of the FIFO. Converts the FIFO read side (rd_en strobe; buf_out valid one cycle after the strobe) into a valid/ready stream for the consuming block. It issues reads on its own, tracks reads in flight, and holds returned words in a small circular buffer. This sustains one word per cycle with no combinational path from out_ready to fifo_rd_en.

Parameters:
WIDTH, 4, data word width; must match the FIFO WIDTH.
BUF_DEPTH, 3, local buffer entries; minimum 3 for full throughput; legal range 2..16.
CNT_W, $clog2(BUF_DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high; clears all state immediately.
fifo_buf_empty  input  1  FIFO buf_empty.
fifo_buf_out  input  WIDTH  FIFO buf_out; valid in the cycle after fifo_rd_en was high.
fifo_rd_en  output  1  FIFO rd_en strobe, one word per high cycle.
out_data  output  WIDTH  head word of the local buffer.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high (pop).
out_count  output  CNT_W  local buffer occupancy, 0..BUF_DEPTH.

Behaviour:
- Reset (async assert, state held while rst=1): out_valid=0, out_count=0, fifo_rd_en=0, out_data=0, pend=0, wr_ptr=0, rd_ptr=0, buffer contents=0.
- State:
  - pend: 1 bit; a read was issued in the previous cycle.
  - occ: occupancy, drives out_count.
  - wr_ptr, rd_ptr: wrap modulo BUF_DEPTH.
- Issue: fifo_rd_en = !rst && !fifo_buf_empty && (occ + pend < BUF_DEPTH).
  - Depends only on registers and fifo_buf_empty, never on out_ready.
  - Each edge: pend <= fifo_rd_en.
- Capture: if pend, write fifo_buf_out into buf[wr_ptr] and advance wr_ptr, wrapping at BUF_DEPTH-1 -> 0.
- Present:
  - out_valid = (occ != 0).
  - out_data = buf[rd_ptr], combinational from registers.
  - out_data is don't-care when out_valid=0.
- Pop: on out_valid && out_ready, advance rd_ptr with wrap.
  - out_ready while out_valid=0 has no effect.
- Occupancy update on each edge:
  - capture and pop together: unchanged.
  - capture only: +1.
  - pop only: -1.
- Latency: fifo_rd_en high in cycle t -> word captured at the end of t+1 -> out_valid high in t+2. First-word latency is 2 cycles from FIFO non-empty.
- Throughput: with out_ready held high and the FIFO non-empty, fifo_rd_en stays high every cycle and one word pops per cycle.
- Backpressure: with out_ready low, at most BUF_DEPTH reads are outstanding (occ+pend). fifo_rd_en falls once occ+pend = BUF_DEPTH.
- FIFO empty mid-stream: fifo_rd_en low. Already-issued reads still land; no phantom capture.
- Overflow: impossible by construction. Assertion: capture never occurs with occ=BUF_DEPTH and no pop.
- Ordering: words leave in exactly FIFO read order; no duplication, no loss.
- Reset mid-operation: buffered words and any in-flight word are discarded. The FIFO state is the FIFO's own concern; the adapter resumes issuing after rst deasserts.

Decomposition:
- Shared package fifo_pkg:
  - WIDTH default constant.
  - typedef fifo_word_t = logic [WIDTH-1:0].
  - function to compute CNT_W.
- One natural sub-module: stream_ring_buf, holding the circular storage, pointers and occ with push/pop ports. The top keeps the issue logic and pend.

Test Plan:
1. Reset: hold rst=1 for 2 cycles while the FIFO is non-empty -> fifo_rd_en=0, out_valid=0, out_count=0 throughout. Pulse rst asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
2. Streaming: FIFO preloaded with 1..5, out_ready=1 -> fifo_rd_en high for 5 consecutive cycles. out_data = 1,2,3,4,5 on 5 consecutive cycles; first out_valid 2 cycles after the first fifo_rd_en.
3. Backpressure: FIFO holds 1..8, out_ready=0 -> exactly 3 fifo_rd_en pulses, out_count=3, fifo_rd_en stays low. Then out_ready=1 -> out_data 1..8 in order, no bubble after the first pop.
4. Empty mid-stream: FIFO holds 1..2, out_ready=1, then write 3 four cycles later -> out_valid drops after word 2. Word 3 appears 2 cycles after the FIFO goes non-empty; out_count never exceeds 1.
5. Reset in flight: assert rst in the cycle after a fifo_rd_en pulse (pend=1) with occ=2 -> out_count=0 and out_valid=0 immediately. After release, the next delivered word is the FIFO's following entry.
6. Random soak: 10000 words, random FIFO writes, random out_ready at 10%..100% duty. A scoreboard queue compares every popped word; require zero mismatches and an out_count <= 3 assertion that never fires.
